vecdot_reduce: RTL

Sequential fp16 reduction stage on the consumer side of the element-wise multiplier array in the attention layer. Accepts one packed vector of `vectdepth` fp16 products per transaction and sums them into one fp16 dot-product score, for example one Q·K attention score. Uses `lanes` shared fp16 adders in a fixed, deterministic summation order, so results are bit-exact and repeatable. Valid/ready on both sides.

---
 rtl/vecdot_reduce_pkg.sv | 28 ++
 rtl/vecdot_reduce_fp16_add.sv | 114 +++++++++++
 rtl/vecdot_reduce.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vecdot_reduce_pkg.sv
// ============================================================================
// Module      : vecdot_reduce_pkg
// Description : Shared fp16 field widths, special encodings and FSM states
//               for the vecdot_reduce dot-product reduction stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vecdot_reduce_pkg;

    localparam int FP16_W     = 16;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
    localparam logic [FP16_W-1:0] FP16_PINF = 16'h7C00;
    localparam logic [FP16_W-1:0] FP16_NINF = 16'hFC00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_FOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vecdot_reduce_fp16_add.sv
// ============================================================================
// Module      : fp16_add
// Description : Combinational fp16 adder, round-to-nearest-even, subnormals
//               flushed to signed zero, overflow saturating to infinity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp16_add
    import vecdot_reduce_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic [FP16_W-1:0] sum
);

    localparam int SIG_W = FP16_MAN_W + 1;
    localparam int EXT_W = 14;
    localparam int DP_W  = SIG_W + EXT_W + 1;
    localparam logic [FP16_EXP_W-1:0] EXP_MAX = '1;

    logic                  sa, sb;
    logic [FP16_EXP_W-1:0] ea, eb;
    logic [FP16_MAN_W-1:0] ma, mb;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;

    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_a_zero = (ea == '0);
    assign w_b_zero = (eb == '0);
    assign w_a_inf  = (ea == EXP_MAX) && (ma == '0);
    assign w_b_inf  = (eb == EXP_MAX) && (mb == '0);
    assign w_a_nan  = (ea == EXP_MAX) && (ma != '0);
    assign w_b_nan  = (eb == EXP_MAX) && (mb != '0);

    logic                  w_swap, w_sx, w_sy;
    logic [FP16_EXP_W-1:0] w_ex, w_ey, w_d;
    logic [FP16_MAN_W-1:0] w_mx, w_my;
    logic [DP_W-1:0]       w_x, w_y, w_s;

    // x is always the larger magnitude so the subtraction never goes negative
    assign w_swap = {eb, mb} > {ea, ma};
    assign w_sx   = w_swap ? sb : sa;
    assign w_sy   = w_swap ? sa : sb;
    assign w_ex   = w_swap ? eb : ea;
    assign w_ey   = w_swap ? ea : eb;
    assign w_mx   = w_swap ? mb : ma;
    assign w_my   = w_swap ? ma : mb;
    assign w_d    = w_ex - w_ey;

    // Beyond 14 places the small operand only matters as a sticky bit
    assign w_x = {1'b0, 1'b1, w_mx, {EXT_W{1'b0}}};
    assign w_y = (w_d > 5'd14) ? DP_W'(1) : ({1'b0, 1'b1, w_my, {EXT_W{1'b0}}} >> w_d);
    assign w_s = (w_sx == w_sy) ? (w_x + w_y) : (w_x - w_y);

    logic [4:0]        w_pos;
    logic [DP_W-2:0]   w_n;
    logic signed [7:0] w_e;

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < DP_W - 1; i++) begin
            if (w_s[i]) w_pos = 5'(i);
        end
        if (w_s[DP_W-1]) begin
            w_n    = w_s[DP_W-1:1];
            w_n[0] = w_s[1] | w_s[0];
            w_e    = $signed(8'(w_ex)) + 8'sd1;
        end else begin
            w_n = w_s[DP_W-2:0] << (5'd24 - w_pos);
            w_e = $signed(8'(w_ex)) - $signed(8'(5'd24 - w_pos));
        end
    end

    logic                  w_rnd;
    logic [SIG_W:0]        w_mr;
    logic signed [7:0]     w_er;
    logic [FP16_MAN_W-1:0] w_mo;

    assign w_rnd = w_n[EXT_W-1] & (w_n[EXT_W] | (|w_n[EXT_W-2:0]));
    assign w_mr  = {1'b0, w_n[DP_W-2:EXT_W]} + (SIG_W+1)'(w_rnd);
    assign w_er  = w_e + (w_mr[SIG_W] ? 8'sd1 : 8'sd0);
    assign w_mo  = w_mr[SIG_W] ? w_mr[SIG_W-1:1] : w_mr[SIG_W-2:0];

    always_comb begin
        sum = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (sa != sb))) begin
            sum = FP16_QNAN;
        end else if (w_a_inf) begin
            sum = a;
        end else if (w_b_inf) begin
            sum = b;
        end else if (w_a_zero && w_b_zero) begin
            sum = {sa & sb, {(FP16_W-1){1'b0}}};
        end else if (w_a_zero) begin
            sum = b;
        end else if (w_b_zero) begin
            sum = a;
        end else if (w_s == '0) begin
            sum = '0;
        end else if (w_er > 8'sd30) begin
            sum = w_sx ? FP16_NINF : FP16_PINF;
        end else if (w_er < 8'sd1) begin
            sum = {w_sx, {(FP16_W-1){1'b0}}};
        end else begin
            sum = {w_sx, w_er[FP16_EXP_W-1:0], w_mo};
        end
    end

endmodule

`default_nettype wire

// File: rtl/vecdot_reduce.sv
// ============================================================================
// Module      : vecdot_reduce
// Description : Sequential fp16 vector sum: lane accumulation followed by a
//               halving fold tree, fixed summation order, valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vecdot_reduce
    import vecdot_reduce_pkg::*;
#(
    parameter int arraysize = 1024,
    parameter int vectdepth = 64,
    parameter int lanes     = 8
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [arraysize-1:0] in_vec,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FP16_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int STEPS = vectdepth / lanes;
    localparam int LW    = (lanes > 1) ? $clog2(lanes) : 1;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SHIFT = lanes * FP16_W;

    state_t                r_state;
    logic [arraysize-1:0]  r_vec;
    logic [FP16_W-1:0]     r_p [lanes];
    logic [CW-1:0]         r_cnt;
    logic [LW-1:0]         r_half;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [FP16_W-1:0]     r_out_data;

    logic [FP16_W-1:0]     w_b   [lanes];
    logic [FP16_W-1:0]     w_sum [lanes];

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // r_vec is shifted down each ACC step so its low slice is always the next row
    always_comb begin : p_opmux
        logic [LW-1:0] idx;
        idx = '0;
        for (int j = 0; j < lanes; j++) begin
            idx    = LW'(j) + r_half;
            w_b[j] = (r_state == ST_FOLD) ? r_p[idx] : r_vec[j*FP16_W +: FP16_W];
        end
    end

    generate
        for (genvar j = 0; j < lanes; j++) begin : g_lane
            fp16_add u_add (
                .a   (r_p[j]),
                .b   (w_b[j]),
                .sum (w_sum[j])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_vec       <= '0;
            for (int j = 0; j < lanes; j++) r_p[j] <= '0;
            r_cnt       <= '0;
            r_half      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_vec      <= in_vec >> SHIFT;
                        for (int j = 0; j < lanes; j++) r_p[j] <= in_vec[j*FP16_W +: FP16_W];
                        r_cnt      <= CW'(1);
                        r_half     <= LW'(lanes / 2);
                        r_state    <= (STEPS > 1) ? ST_ACC : ST_FOLD;
                    end
                end
                ST_ACC: begin
                    for (int j = 0; j < lanes; j++) r_p[j] <= w_sum[j];
                    r_vec <= r_vec >> SHIFT;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(STEPS - 1)) r_state <= ST_FOLD;
                end
                ST_FOLD: begin
                    for (int j = 0; j < lanes; j++) begin
                        if (LW'(j) < r_half) r_p[j] <= w_sum[j];
                    end
                    r_half <= r_half >> 1;
                    if (r_half == LW'(1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sum[0];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
